// File: rtl/jtframe_ddr_pkg.sv
// Shared definitions for arbiters that sit in front of the DDR3 read port.
package jtframe_ddr_pkg;

    localparam int unsigned DDR_AW = 29;
    localparam int unsigned DDR_BW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } ddr_state_t;

    // A zero-length burst is meaningless to the controller; treat it as one word.
    function automatic logic [DDR_BW-1:0] ddr_burst_fix(input logic [DDR_BW-1:0] b);
        return (b == '0) ? DDR_BW'(1) : b;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin selector: first set request searching upward
// from ptr+1, wrapping modulo NREQ.
module jtframe_rr_pick #(
    parameter int unsigned NREQ = 2
)(
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    valid
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] cand;

    // Scan candidates in priority order, latching onto the first requester found
    always_comb begin
        win     = '0;
        win_idx = '0;
        valid   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(ptr) + k) % NREQ);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                win_idx   = cand;
                win[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_ddram_arb.sv
// Round-robin arbiter for the shared DDR3 read port. One requester owns the
// port from grant until its last beat (or a data timeout).
module jtframe_ddram_arb
    import jtframe_ddr_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned TOUT = 1023
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DDR_AW-1:0] req_addr,
    input  logic [NREQ*DDR_BW-1:0] req_burst,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        dready,
    output logic                   done,
    output logic                   err,
    input  logic                   ddram_busy,
    output logic                   ddram_rd,
    output logic [DDR_AW-1:0]      ddram_addr,
    output logic [DDR_BW-1:0]      ddram_burstcnt,
    input  logic                   ddram_dout_ready
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TOUT + 1);

    ddr_state_t       state, state_nx;
    logic [IW-1:0]    ptr;
    logic [DDR_BW-1:0] beat;
    logic [TW-1:0]    tcnt;

    logic [NREQ-1:0]  pick_win;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [DDR_AW-1:0] sel_addr;
    logic [DDR_BW-1:0] sel_burst;

    logic grant_go, accept, last_beat, tout_hit;

    jtframe_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

    assign sel_addr  = req_addr[32'(pick_idx)*DDR_AW +: DDR_AW];
    assign sel_burst = req_burst[32'(pick_idx)*DDR_BW +: DDR_BW];

    // Data strobes go only to the owner, and only while a burst is expected
    assign dready = (state == DATA && ddram_dout_ready) ? gnt : '0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and transaction events
    always_comb begin
        state_nx  = state;
        grant_go  = 1'b0;
        accept    = 1'b0;
        last_beat = 1'b0;
        tout_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_go = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!ddram_busy) begin
                    accept   = 1'b1;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (ddram_dout_ready) begin
                    if (beat == DDR_BW'(1)) begin
                        last_beat = 1'b1;
                        state_nx  = IDLE;
                    end
                end else if (tcnt == TW'(TOUT - 1)) begin
                    // the increment on this edge would make the count reach TOUT
                    tout_hit = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant, command, counters and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt            <= '0;
            ptr            <= IW'(NREQ - 1);
            ddram_rd       <= 1'b0;
            ddram_addr     <= '0;
            ddram_burstcnt <= '0;
            beat           <= '0;
            tcnt           <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            done <= last_beat;
            err  <= tout_hit;
            if (grant_go) begin
                gnt            <= pick_win;
                ptr            <= pick_idx;
                ddram_addr     <= sel_addr;
                ddram_burstcnt <= ddr_burst_fix(sel_burst);
                ddram_rd       <= 1'b1;
            end
            if (accept) begin
                ddram_rd <= 1'b0;
                beat     <= ddram_burstcnt;
                tcnt     <= '0;
            end
            if (state == DATA) begin
                if (ddram_dout_ready) begin
                    beat <= beat - DDR_BW'(1);
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
            if (last_beat || tout_hit) gnt <= '0;
        end
    end

endmodule

// File: tb/tb_jtframe_ddram_arb.sv
// Directed bench for jtframe_ddram_arb with NREQ=2, TOUT=15.
module tb_jtframe_ddram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [28:0] addr0, addr1;
    logic [7:0]  burst0, burst1;
    logic [1:0]  gnt, dready;
    logic        done, err;
    logic        ddram_busy, ddram_rd, ddram_dout_ready;
    logic [28:0] ddram_addr;
    logic [7:0]  ddram_burstcnt;

    int nvec = 0;
    int nerr = 0;
    logic [1:0]  exp_g;
    logic [28:0] exp_a;

    always #5 clk = ~clk;

    jtframe_ddram_arb #(
        .NREQ (2),
        .TOUT (15)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .req_addr         ({addr1, addr0}),
        .req_burst        ({burst1, burst0}),
        .gnt              (gnt),
        .dready           (dready),
        .done             (done),
        .err              (err),
        .ddram_busy       (ddram_busy),
        .ddram_rd         (ddram_rd),
        .ddram_addr       (ddram_addr),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_dout_ready (ddram_dout_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 32'h0);
        chk({tag, "_dready"}, 32'(dready), 32'h0);
        chk({tag, "_done"},  32'(done), 32'h0);
        chk({tag, "_err"},   32'(err), 32'h0);
        chk({tag, "_rd"},    32'(ddram_rd), 32'h0);
        chk({tag, "_addr"},  32'(ddram_addr), 32'h0);
        chk({tag, "_bcnt"},  32'(ddram_burstcnt), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; addr0 = '0; addr1 = '0; burst0 = '0; burst1 = '0;
        ddram_busy = 1'b0; ddram_dout_ready = 1'b0;
        step; step;
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // 1: single request, 8-beat burst
        req = 2'b01; addr0 = 29'h0300_0000; burst0 = 8'd8;
        step;
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_rd", 32'(ddram_rd), 32'h1);
        chk("t1_addr", 32'(ddram_addr), 32'h0300_0000);
        chk("t1_bcnt", 32'(ddram_burstcnt), 32'd8);
        req = 2'b00;
        step;
        chk("t1_rd_drop", 32'(ddram_rd), 32'h0);
        ddram_dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t1_dready", 32'(dready), 32'h1);
            chk("t1_done_early", 32'(done), 32'h0);
            step;
        end
        ddram_dout_ready = 1'b0;
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_gnt_rel", 32'(gnt), 32'h0);
        step;
        chk("t1_done_pulse", 32'(done), 32'h0);

        // 2: contention from a fresh pointer, alternating grants
        rst_n = 1'b0; step; rst_n = 1'b1;
        addr0 = 29'h0000_1000; addr1 = 29'h0000_2000; burst0 = 8'd4; burst1 = 8'd4;
        req = 2'b11;
        step;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (t % 2 == 0) ? 29'h0000_1000 : 29'h0000_2000;
            chk("t2_gnt", 32'(gnt), 32'(exp_g));
            chk("t2_rd", 32'(ddram_rd), 32'h1);
            chk("t2_addr", 32'(ddram_addr), 32'(exp_a));
            step;
            chk("t2_rd_drop", 32'(ddram_rd), 32'h0);
            ddram_dout_ready = 1'b1;
            for (int b = 0; b < 4; b++) begin
                #1;
                chk("t2_dready", 32'(dready), 32'(exp_g));
                step;
            end
            ddram_dout_ready = 1'b0;
            chk("t2_done", 32'(done), 32'h1);
            chk("t2_gnt_rel", 32'(gnt), 32'h0);
            if (t == 3) req = 2'b00;
            step;
        end

        // 3: controller busy for the first 5 ISSUE cycles
        req = 2'b10; addr1 = 29'h123_4567; burst1 = 8'd2; ddram_busy = 1'b1;
        step;
        req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            chk("t3_rd_hold", 32'(ddram_rd), 32'h1);
            chk("t3_addr", 32'(ddram_addr), 32'h123_4567);
            chk("t3_gnt", 32'(gnt), 32'h2);
            step;
        end
        ddram_busy = 1'b0;
        chk("t3_rd_last", 32'(ddram_rd), 32'h1);
        step;
        chk("t3_rd_drop", 32'(ddram_rd), 32'h0);
        ddram_dout_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            #1;
            chk("t3_dready", 32'(dready), 32'h2);
            chk("t3_rd_once", 32'(ddram_rd), 32'h0);
            step;
        end
        ddram_dout_ready = 1'b0;
        chk("t3_done", 32'(done), 32'h1);
        step;

        // 4: timeout after 2 of 4 beats
        req = 2'b01; burst0 = 8'd4;
        step;
        req = 2'b00;
        chk("t4_gnt", 32'(gnt), 32'h1);
        step;
        ddram_dout_ready = 1'b1;
        step; step;
        ddram_dout_ready = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step;
            chk("t4_err_early", 32'(err), 32'h0);
            chk("t4_gnt_held", 32'(gnt), 32'h1);
        end
        step;
        chk("t4_err", 32'(err), 32'h1);
        chk("t4_gnt_rel", 32'(gnt), 32'h0);
        chk("t4_done_none", 32'(done), 32'h0);
        step;
        chk("t4_err_pulse", 32'(err), 32'h0);
        ddram_dout_ready = 1'b1;
        #1;
        chk("t4_stray_dready", 32'(dready), 32'h0);
        step;
        ddram_dout_ready = 1'b0;
        chk("t4_stray_gnt", 32'(gnt), 32'h0);
        chk("t4_stray_rd", 32'(ddram_rd), 32'h0);
        chk("t4_stray_done", 32'(done), 32'h0);

        // 5: reset in the middle of DATA
        req = 2'b01; burst0 = 8'd8; addr0 = 29'h0300_0000;
        step;
        req = 2'b00;
        chk("t5_gnt", 32'(gnt), 32'h1);
        step;
        ddram_dout_ready = 1'b1;
        step; step; step;
        rst_n = 1'b0;
        step;
        #1;
        chk_idle_outputs("t5_rst");
        rst_n = 1'b1;
        step;
        chk("t5_post_gnt", 32'(gnt), 32'h0);
        chk("t5_post_dready", 32'(dready), 32'h0);
        chk("t5_post_done", 32'(done), 32'h0);
        ddram_dout_ready = 1'b0;
        req = 2'b10; burst1 = 8'd1;
        step;
        chk("t5_gnt_b", 32'(gnt), 32'h2);
        req = 2'b00;
        step;
        ddram_dout_ready = 1'b1;
        #1;
        chk("t5_dready_b", 32'(dready), 32'h2);
        step;
        ddram_dout_ready = 1'b0;
        chk("t5_done_b", 32'(done), 32'h1);

        // 6: zero burst becomes a single word; pointer now favours requester 0
        req = 2'b11; burst0 = 8'd0;
        step;
        chk("t5_gnt_a_first", 32'(gnt), 32'h1);
        chk("t6_bcnt", 32'(ddram_burstcnt), 32'd1);
        req = 2'b00;
        step;
        ddram_dout_ready = 1'b1;
        #1;
        chk("t6_dready", 32'(dready), 32'h1);
        step;
        ddram_dout_ready = 1'b0;
        chk("t6_done", 32'(done), 32'h1);
        chk("t6_gnt_rel", 32'(gnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
